// File: rtl/riscv_core_cache_axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read master between I-cache and D-cache refills.
// The grant is locked per refill, and a watchdog aborts any refill that hangs.
module riscv_core_cache_axi_rd_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int AXI_DATA_WIDTH = 256,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 11
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_ic_read_req,
  input  logic [ADDR_WIDTH-1:0]     i_ic_read_address,
  output logic                      o_ic_read_done,
  output logic                      o_ic_read_err,
  output logic [AXI_DATA_WIDTH-1:0] o_ic_block,
  input  logic                      i_dc_read_req,
  input  logic [ADDR_WIDTH-1:0]     i_dc_read_address,
  output logic                      o_dc_read_done,
  output logic                      o_dc_read_err,
  output logic [AXI_DATA_WIDTH-1:0] o_dc_block,
  output logic                      o_mem_read_req,
  output logic [ADDR_WIDTH-1:0]     o_mem_read_address,
  input  logic                      i_mem_read_done,
  input  logic [AXI_DATA_WIDTH-1:0] i_block_from_axi,
  output logic [1:0]                o_grant,
  output logic                      o_timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IC = 2'd1,
    BUSY_DC = 2'd2
  } state_t;

  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] TO_LAST = WD_EN ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t                  state_q, state_d;
  logic                    req_q, req_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]              grant_q, grant_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    last_dc_q, last_dc_d;
  logic                    block_q, block_d;
  logic                    busy_s, done_s, fire_s, ic_elig_s, dc_elig_s;

  // Done/abort qualification; pulses are suppressed while reset is asserted.
  always_comb begin
    busy_s    = (state_q != IDLE);
    done_s    = busy_s & i_mem_read_done & i_rst_n;
    fire_s    = WD_EN & busy_s & (cnt_q == TO_LAST) & ~i_mem_read_done & i_rst_n;
    // last_dc_q names the cache just released; block_q keeps it out for one IDLE cycle
    ic_elig_s = i_ic_read_req & ~(block_q & ~last_dc_q);
    dc_elig_s = i_dc_read_req & ~(block_q & last_dc_q);
  end

  assign o_ic_read_done     = done_s & (state_q == BUSY_IC);
  assign o_dc_read_done     = done_s & (state_q == BUSY_DC);
  assign o_ic_read_err      = fire_s & (state_q == BUSY_IC);
  assign o_dc_read_err      = fire_s & (state_q == BUSY_DC);
  assign o_timeout          = fire_s;
  assign o_ic_block         = i_block_from_axi;
  assign o_dc_block         = i_block_from_axi;
  assign o_mem_read_req     = req_q;
  assign o_mem_read_address = addr_q;
  assign o_grant            = grant_q;

  // Next-state: arbitration in IDLE, refill tracking and watchdog in BUSY.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    last_dc_d = last_dc_q;
    block_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (dc_elig_s && (!ic_elig_s || !last_dc_q)) begin
          state_d = BUSY_DC;
          req_d   = 1'b1;
          addr_d  = i_dc_read_address;
          grant_d = 2'b10;
          cnt_d   = {CNT_WIDTH{1'b0}};
        end else if (ic_elig_s) begin
          state_d = BUSY_IC;
          req_d   = 1'b1;
          addr_d  = i_ic_read_address;
          grant_d = 2'b01;
          cnt_d   = {CNT_WIDTH{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_IC, BUSY_DC: begin
        if (done_s || fire_s) begin
          state_d   = IDLE;
          req_d     = 1'b0;
          grant_d   = 2'b00;
          last_dc_d = (state_q == BUSY_DC);
          block_d   = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        grant_d = 2'b00;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      addr_q    <= {ADDR_WIDTH{1'b0}};
      grant_q   <= 2'b00;
      cnt_q     <= {CNT_WIDTH{1'b0}};
      last_dc_q <= 1'b0;
      block_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      last_dc_q <= last_dc_d;
      block_q   <= block_d;
    end
  end

endmodule

// File: tb/tb_riscv_core_cache_axi_rd_arbiter.sv
// Self-checking bench for the cache refill read arbiter: directed scenarios plus
// randomized traffic compared cycle by cycle against a transaction-level reference model.
module tb_riscv_core_cache_axi_rd_arbiter;

  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ic_req, dc_req, mem_done;
  logic [31:0]  ic_addr, dc_addr;
  logic [255:0] blk;
  logic         ic_done, ic_err, dc_done, dc_err, mem_req, timeout;
  logic [255:0] ic_blk, dc_blk;
  logic [31:0]  mem_addr;
  logic [1:0]   grant;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: owner 0=none 1=IC 2=DC; age = completed BUSY cycles of this refill
  int          m_owner, m_age, m_last, m_cool;
  logic        m_req;
  logic [31:0] m_addr;
  logic        e_icd, e_ice, e_dcd, e_dce, e_to;
  logic [39:0] exp_vec;

  always #5 clk = ~clk;

  riscv_core_cache_axi_rd_arbiter #(
    .ADDR_WIDTH(32), .AXI_DATA_WIDTH(256), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ic_read_req(ic_req), .i_ic_read_address(ic_addr),
    .o_ic_read_done(ic_done), .o_ic_read_err(ic_err), .o_ic_block(ic_blk),
    .i_dc_read_req(dc_req), .i_dc_read_address(dc_addr),
    .o_dc_read_done(dc_done), .o_dc_read_err(dc_err), .o_dc_block(dc_blk),
    .o_mem_read_req(mem_req), .o_mem_read_address(mem_addr),
    .i_mem_read_done(mem_done), .i_block_from_axi(blk),
    .o_grant(grant), .o_timeout(timeout)
  );

  function automatic logic [39:0] obs_vec();
    return {mem_req, grant, ic_done, ic_err, dc_done, dc_err, timeout, mem_addr};
  endfunction

  task automatic model_eval();
    logic act;
    logic [1:0] g;
    act   = (m_owner != 0) && rst_n;
    e_icd = act && m_owner == 1 && mem_done;
    e_dcd = act && m_owner == 2 && mem_done;
    e_to  = act && m_age == TO - 1 && !mem_done;
    e_ice = e_to && m_owner == 1;
    e_dce = e_to && m_owner == 2;
    g = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    exp_vec = {m_req, g, e_icd, e_ice, e_dcd, e_dce, e_to, m_addr};
  endtask

  task automatic model_next();
    int pick;
    logic ic_ok, dc_ok;
    if (!rst_n) begin
      m_owner = 0; m_age = 0; m_last = 1; m_cool = 0; m_req = 1'b0; m_addr = 32'h0;
    end else if (m_owner != 0) begin
      if (mem_done || m_age == TO - 1) begin
        m_last = m_owner; m_cool = m_owner; m_owner = 0; m_req = 1'b0;
      end else begin
        m_age++;
      end
    end else begin
      ic_ok  = ic_req && m_cool != 1;
      dc_ok  = dc_req && m_cool != 2;
      m_cool = 0;
      if (ic_ok && dc_ok) pick = (m_last == 1) ? 2 : 1;
      else if (ic_ok)     pick = 1;
      else if (dc_ok)     pick = 2;
      else                pick = 0;
      if (pick != 0) begin
        m_owner = pick; m_age = 0; m_req = 1'b1;
        m_addr  = (pick == 1) ? ic_addr : dc_addr;
      end
    end
  endtask

  task automatic tick();
    model_next();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ic_req = 1'b0; dc_req = 1'b0; mem_done = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    model_eval();
    n_checks++;
    if (obs_vec() !== 40'h0 || exp_vec !== 40'h0) $display("FAIL reset_state got %h want %h", obs_vec(), 40'h0);
    else n_pass++;
  endtask

  task automatic test_single_ic();
    int dones = 0;
    do_reset();
    ic_addr = 32'h0000_1000;
    for (int c = 0; c < 10; c++) begin
      ic_req = (c <= 6); mem_done = (c == 6);
      #1; model_eval();
      n_checks++;
      if (obs_vec() !== exp_vec) $display("FAIL single_ic c=%0d got %h want %h", c, obs_vec(), exp_vec);
      else n_pass++;
      if (c == 1) begin
        n_checks++;
        if (!(mem_req === 1'b1 && mem_addr === 32'h0000_1000 && grant === 2'b01))
          $display("FAIL single_ic_grant req=%b addr=%h grant=%b want 1/00001000/01", mem_req, mem_addr, grant);
        else n_pass++;
      end
      if (c == 7) begin
        n_checks++;
        if (grant !== 2'b00) $display("FAIL single_ic_release grant=%b want 00", grant);
        else n_pass++;
      end
      dones += int'(ic_done === 1'b1);
      tick();
    end
    n_checks++;
    if (dones != 1) $display("FAIL single_ic_pulses got %0d want 1", dones);
    else n_pass++;
  endtask

  task automatic test_both_after_reset();
    do_reset();
    ic_addr = 32'h0000_2000; dc_addr = 32'h0000_3000;
    for (int c = 0; c < 10; c++) begin
      dc_req = (c <= 3); ic_req = (c <= 7); mem_done = (c == 3 || c == 7);
      #1; model_eval();
      n_checks++;
      if (obs_vec() !== exp_vec) $display("FAIL both c=%0d got %h want %h", c, obs_vec(), exp_vec);
      else n_pass++;
      if (c == 1 || c == 4 || c == 5) begin
        n_checks++;
        if (grant !== ((c == 1) ? 2'b10 : (c == 4) ? 2'b00 : 2'b01))
          $display("FAIL both_order c=%0d grant=%b", c, grant);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_dc_continuous();
    logic [1:0] seq [$];
    logic [1:0] prev = 2'b00;
    logic [1:0] want [3];
    want[0] = 2'b10; want[1] = 2'b01; want[2] = 2'b10;
    do_reset();
    ic_addr = 32'h0000_4400; dc_addr = 32'h0000_5500;
    ic_req = 1'b1; dc_req = 1'b1;
    for (int c = 0; c < 12; c++) begin
      mem_done = (m_owner != 0 && m_age == 1);
      #1; model_eval();
      n_checks++;
      if (obs_vec() !== exp_vec) $display("FAIL dc_cont c=%0d got %h want %h", c, obs_vec(), exp_vec);
      else n_pass++;
      if (grant !== 2'b00 && prev === 2'b00) seq.push_back(grant);
      prev = grant;
      if (e_icd) begin
        tick(); ic_req = 1'b0;
      end else begin
        tick();
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (seq.size() <= i) $display("FAIL dc_cont_seq%0d missing grant", i);
      else if (seq[i] !== want[i]) $display("FAIL dc_cont_seq%0d got %b want %b", i, seq[i], want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int tos = 0;
    do_reset();
    ic_addr = 32'h0000_6000;
    for (int c = 0; c < 15; c++) begin
      ic_req = (c <= 8); mem_done = (c == 12);
      #1; model_eval();
      n_checks++;
      if (obs_vec() !== exp_vec) $display("FAIL timeout c=%0d got %h want %h", c, obs_vec(), exp_vec);
      else n_pass++;
      if (c == 8) begin
        n_checks++;
        if (!(timeout === 1'b1 && ic_err === 1'b1)) $display("FAIL timeout_fire to=%b err=%b want 1/1", timeout, ic_err);
        else n_pass++;
      end
      if (c == 12) begin
        n_checks++;
        if (ic_done !== 1'b0 || dc_done !== 1'b0) $display("FAIL late_done ic=%b dc=%b want 0/0", ic_done, dc_done);
        else n_pass++;
      end
      tos += int'(timeout === 1'b1);
      tick();
    end
    n_checks++;
    if (tos != 1) $display("FAIL timeout_count got %0d want 1", tos);
    else n_pass++;
  endtask

  task automatic test_done_at_last();
    do_reset();
    dc_addr = 32'h0000_7000;
    for (int c = 0; c < 11; c++) begin
      dc_req = (c <= 8); mem_done = (c == 8);
      #1; model_eval();
      n_checks++;
      if (obs_vec() !== exp_vec) $display("FAIL done_last c=%0d got %h want %h", c, obs_vec(), exp_vec);
      else n_pass++;
      if (c == 8) begin
        n_checks++;
        if (!(dc_done === 1'b1 && timeout === 1'b0 && dc_err === 1'b0))
          $display("FAIL done_wins done=%b to=%b err=%b want 1/0/0", dc_done, timeout, dc_err);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    dc_addr = 32'h0000_5000;
    for (int c = 0; c < 9; c++) begin
      dc_req = (c <= 3); rst_n = (c != 3); mem_done = (c == 6);
      #1; model_eval();
      n_checks++;
      if (obs_vec() !== exp_vec) $display("FAIL rst_mid c=%0d got %h want %h", c, obs_vec(), exp_vec);
      else n_pass++;
      if (c == 4 || c == 6) begin
        n_checks++;
        if (obs_vec() !== 40'h0) $display("FAIL rst_mid_quiet c=%0d got %h want 0", c, obs_vec());
        else n_pass++;
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic ic_ev, dc_ev;
    do_reset();
    ic_ev = 1'b0; dc_ev = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (ic_ev) ic_req = ($urandom % 2 == 0);
      else if (!ic_req && $urandom % 3 == 0) begin ic_req = 1'b1; ic_addr = $urandom & 32'hFFFF_FFE0; end
      if (dc_ev) dc_req = ($urandom % 2 == 0);
      else if (!dc_req && $urandom % 3 == 0) begin dc_req = 1'b1; dc_addr = $urandom & 32'hFFFF_FFE0; end
      mem_done = ($urandom % 4 == 0);
      blk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      #1; model_eval();
      n_checks++;
      if (obs_vec() !== exp_vec) $display("FAIL random c=%0d got %h want %h", c, obs_vec(), exp_vec);
      else n_pass++;
      n_checks++;
      if (ic_blk !== blk || dc_blk !== blk) $display("FAIL random_block c=%0d ic=%h dc=%h", c, ic_blk[31:0], dc_blk[31:0]);
      else n_pass++;
      ic_ev = e_icd | e_ice;
      dc_ev = e_dcd | e_dce;
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; ic_req = 1'b0; dc_req = 1'b0; mem_done = 1'b0;
    ic_addr = 32'h0; dc_addr = 32'h0; blk = '0;
    m_owner = 0; m_age = 0; m_last = 1; m_cool = 0; m_req = 1'b0; m_addr = 32'h0;
    @(negedge clk);
    test_reset();
    test_single_ic();
    test_both_after_reset();
    test_dc_continuous();
    test_timeout();
    test_done_at_last();
    test_reset_mid_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout bench did not finish in time");
    $fatal(1);
  end

endmodule
